// File: rtl/mic1_regfile_pkg.sv
// mic1_pkg: shared widths, reset values, C-bus write-enable bit indices and B-bus source codes
package mic1_pkg;
  localparam int DATA_W = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RESET_SP  = 32'h0000_8000;
  localparam logic [31:0] RESET_LV  = 32'h0000_8000;
  localparam logic [31:0] RESET_CPP = 32'h0000_4000;
  localparam int C_MAR = 0;
  localparam int C_MDR = 1;
  localparam int C_PC  = 2;
  localparam int C_SP  = 3;
  localparam int C_LV  = 4;
  localparam int C_CPP = 5;
  localparam int C_TOS = 6;
  localparam int C_OPC = 7;
  localparam int C_H   = 8;
  typedef enum logic [3:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } b_sel_e;
endpackage

// File: rtl/mic1_regfile_mem_port.sv
// mic1_mem_port: one memory channel - request pulse, outstanding-read flag, return capture; MIC1_RF_ERR_EN adds a sticky protocol error
module mic1_mem_port (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rd,
  input  logic i_wr,
  input  logic i_rvalid,
  output logic o_rd,
  output logic o_wr,
  output logic o_pending,
  output logic o_capture,
  output logic o_err
);
  logic r_rd, r_wr, r_pending;
  logic w_issue_rd, w_issue_wr;
  assign w_issue_rd = i_rd & ~i_wr & ~r_pending;
  assign w_issue_wr = i_wr & ~i_rd & ~r_pending;
  assign o_capture  = i_rvalid & r_pending;
  assign o_rd       = r_rd;
  assign o_wr       = r_wr;
  assign o_pending  = r_pending;
  // one-cycle request pulses; a read stays outstanding until its return strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_rd      <= w_issue_rd;
      r_wr      <= w_issue_wr;
      r_pending <= r_pending ? ~i_rvalid : w_issue_rd;
    end
`ifdef MIC1_RF_ERR_EN
  logic r_err;
  // sticky flag: read+write clash, command while a read is outstanding, or a stray return
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else r_err <= r_err | (i_rd & i_wr) | ((i_rd | i_wr) & r_pending) | (i_rvalid & ~r_pending);
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: rtl/mic1_regfile.sv
// mic1_regfile: MIC-1 register file driving B/H buses and owning the data/fetch handshakes; MIC1_RF_ERR_EN enables the sticky err output
module mic1_regfile #(
  parameter int          DATA_W    = mic1_pkg::DATA_W,
  parameter logic [31:0] RESET_PC  = mic1_pkg::RESET_PC,
  parameter logic [31:0] RESET_SP  = mic1_pkg::RESET_SP,
  parameter logic [31:0] RESET_LV  = mic1_pkg::RESET_LV,
  parameter logic [31:0] RESET_CPP = mic1_pkg::RESET_CPP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] c_bus,
  input  logic [8:0]        c_sel,
  input  logic [3:0]        b_sel,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  output logic [DATA_W-1:0] b_bus,
  output logic [DATA_W-1:0] h_bus,
  output logic              busy,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [31:0]       dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_rvalid,
  input  logic [7:0]        imem_rdata,
  output logic              err
);
  import mic1_pkg::*;
  logic [DATA_W-1:0] r_mar, r_mdr, r_pc, r_sp, r_lv, r_cpp, r_tos, r_opc, r_h;
  logic [7:0]        r_mbr;
  logic w_d_rd, w_d_wr, w_d_pend, w_d_cap, w_d_err;
  logic w_f_rd, w_f_wr, w_f_pend, w_f_cap, w_f_err;
  mic1_mem_port u_dport (
    .clk(clk), .rst_n(rst_n), .i_rd(rd), .i_wr(wr), .i_rvalid(dmem_rvalid),
    .o_rd(w_d_rd), .o_wr(w_d_wr), .o_pending(w_d_pend), .o_capture(w_d_cap), .o_err(w_d_err)
  );
  mic1_mem_port u_fport (
    .clk(clk), .rst_n(rst_n), .i_rd(fetch), .i_wr(1'b0), .i_rvalid(imem_rvalid),
    .o_rd(w_f_rd), .o_wr(w_f_wr), .o_pending(w_f_pend), .o_capture(w_f_cap), .o_err(w_f_err)
  );
  // C-bus writes; a data return overrides a same-edge C-bus write to MDR, a fetch return loads MBR
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mar <= '0;
      r_mdr <= '0;
      r_pc  <= DATA_W'(RESET_PC);
      r_mbr <= '0;
      r_sp  <= DATA_W'(RESET_SP);
      r_lv  <= DATA_W'(RESET_LV);
      r_cpp <= DATA_W'(RESET_CPP);
      r_tos <= '0;
      r_opc <= '0;
      r_h   <= '0;
    end else begin
      if (c_sel[C_MAR]) r_mar <= c_bus;
      r_mdr <= w_d_cap ? dmem_rdata : c_sel[C_MDR] ? c_bus : r_mdr;
      if (c_sel[C_PC])  r_pc  <= c_bus;
      if (w_f_cap)      r_mbr <= imem_rdata;
      if (c_sel[C_SP])  r_sp  <= c_bus;
      if (c_sel[C_LV])  r_lv  <= c_bus;
      if (c_sel[C_CPP]) r_cpp <= c_bus;
      if (c_sel[C_TOS]) r_tos <= c_bus;
      if (c_sel[C_OPC]) r_opc <= c_bus;
      if (c_sel[C_H])   r_h   <= c_bus;
    end
  // B-bus source mux; unused codes drive zero
  always_comb begin
    b_bus = '0;
    case (b_sel_e'(b_sel))
      B_MDR:   b_bus = r_mdr;
      B_PC:    b_bus = r_pc;
      B_MBR:   b_bus = {{(DATA_W-8){r_mbr[7]}}, r_mbr};
      B_MBRU:  b_bus = DATA_W'(r_mbr);
      B_SP:    b_bus = r_sp;
      B_LV:    b_bus = r_lv;
      B_CPP:   b_bus = r_cpp;
      B_TOS:   b_bus = r_tos;
      B_OPC:   b_bus = r_opc;
      default: b_bus = '0;
    endcase
  end
  assign h_bus      = r_h;
  assign busy       = w_d_pend | w_d_rd | w_f_pend | w_f_rd;
  assign dmem_rd    = w_d_rd;
  assign dmem_wr    = w_d_wr;
  assign dmem_addr  = 32'(r_mar) << 2;
  assign dmem_wdata = r_mdr;
  assign imem_req   = w_f_rd | w_f_wr;
  assign imem_addr  = 32'(r_pc);
  assign err        = w_d_err | w_f_err;
endmodule

// File: tb/tb_mic1_regfile.sv
// tb_mic1_regfile: directed and randomized checks of mic1_regfile against a register-array reference model
module tb_mic1_regfile;
  localparam int MAR = 0, MDR = 1, PC = 2, SP = 3, LV = 4, CPP = 5, TOS = 6, OPC = 7, H = 8;
  logic        clk = 0, rst_n = 0;
  logic [31:0] c_bus = 0;
  logic [8:0]  c_sel = 0;
  logic [3:0]  b_sel = 0;
  logic        rd = 0, wr = 0, fetch = 0;
  logic [31:0] b_bus, h_bus, dmem_addr, dmem_wdata, imem_addr;
  logic        busy, dmem_rd, dmem_wr, imem_req, err;
  logic        dmem_rvalid = 0, imem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;
  logic [7:0]  imem_rdata = 0;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_reg [9];
  logic [7:0]  m_mbr;
  bit m_dpend, m_fpend, m_drd, m_dwr, m_freq, m_err;
  bit exp_err_en;

  mic1_regfile dut (
    .clk(clk), .rst_n(rst_n), .c_bus(c_bus), .c_sel(c_sel), .b_sel(b_sel),
    .rd(rd), .wr(wr), .fetch(fetch), .b_bus(b_bus), .h_bus(h_bus), .busy(busy),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_b(input logic [3:0] s);
    if (s == 0) return m_reg[MDR];
    if (s == 1) return m_reg[PC];
    if (s == 2) return 32'(int'($signed(m_mbr)));
    if (s == 3) return {24'h0, m_mbr};
    if (s <= 8) return m_reg[s - 1];
    return 32'h0;
  endfunction

  // reference model: registers as an array indexed by c_sel bit, requests as pending flags
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_reg[SP] = 32'h8000; m_reg[LV] = 32'h8000; m_reg[CPP] = 32'h4000;
      m_mbr = 0; m_dpend = 0; m_fpend = 0; m_drd = 0; m_dwr = 0; m_freq = 0; m_err = 0;
    end else begin
      m_err = m_err | (rd && wr) | ((rd || wr) && m_dpend) | (dmem_rvalid && !m_dpend)
                    | (fetch && m_fpend) | (imem_rvalid && !m_fpend);
      m_drd = rd && !wr && !m_dpend;
      m_dwr = wr && !rd && !m_dpend;
      m_freq = fetch && !m_fpend;
      for (int i = 0; i < 9; i++) if (c_sel[i]) m_reg[i] = c_bus;
      if (dmem_rvalid && m_dpend) m_reg[MDR] = dmem_rdata;
      if (imem_rvalid && m_fpend) m_mbr = imem_rdata;
      m_dpend = m_drd || (m_dpend && !dmem_rvalid);
      m_fpend = m_freq || (m_fpend && !imem_rvalid);
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    #2;
    chk("b_bus", b_bus, exp_b(b_sel));
    chk("h_bus", h_bus, m_reg[H]);
    chk("busy", {31'h0, busy}, {31'h0, m_dpend || m_fpend || m_drd || m_freq});
    chk("dmem_rd", {31'h0, dmem_rd}, {31'h0, m_drd});
    chk("dmem_wr", {31'h0, dmem_wr}, {31'h0, m_dwr});
    chk("imem_req", {31'h0, imem_req}, {31'h0, m_freq});
    chk("dmem_addr", dmem_addr, m_reg[MAR] << 2);
    chk("dmem_wdata", dmem_wdata, m_reg[MDR]);
    chk("imem_addr", imem_addr, m_reg[PC]);
    chk("err", {31'h0, err}, {31'h0, exp_err_en & m_err});
  end

  initial begin
`ifdef MIC1_RF_ERR_EN
    exp_err_en = 1;
`else
    exp_err_en = 0;
`endif
    @(negedge clk); b_sel = 4; #3;
    chk("rst_sp_b", b_bus, 32'h8000);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_req", {29'h0, dmem_rd, dmem_wr, imem_req}, 32'h0);
    chk("rst_pc", imem_addr, 32'h0);
    rst_n = 1;
    @(negedge clk); c_bus = 32'h1234_5678; c_sel = 9'h1FF;
    @(negedge clk); c_sel = 0;
    for (int s = 0; s < 9; s++) begin
      if (s == 2 || s == 3) continue;
      b_sel = 4'(s); #1;
      chk("all_b", b_bus, 32'h1234_5678);
    end
    chk("all_h", h_bus, 32'h1234_5678);
    chk("all_mar", dmem_addr, 32'h48D1_59E0);
    b_sel = 12; #1; chk("b12_zero", b_bus, 32'h0);
    @(negedge clk); c_bus = 5; c_sel = 9'h001; rd = 1;
    @(negedge clk); c_sel = 0; rd = 0; #3;
    chk("rd_pulse", {31'h0, dmem_rd}, 32'h1);
    chk("rd_addr", dmem_addr, 32'h14);
    chk("rd_busy", {31'h0, busy}, 32'h1);
    @(negedge clk); #3;
    chk("rd_once", {31'h0, dmem_rd}, 32'h0);
    chk("rd_busy2", {31'h0, busy}, 32'h1);
    @(negedge clk); dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF; c_sel = 9'h002; c_bus = 32'h1;
    @(negedge clk); dmem_rvalid = 0; c_sel = 0; b_sel = 0; #3;
    chk("mdr_mem_wins", b_bus, 32'hDEAD_BEEF);
    chk("rd_done_busy", {31'h0, busy}, 32'h0);
    @(negedge clk); fetch = 1;
    @(negedge clk); fetch = 0; imem_rvalid = 1; imem_rdata = 8'h9C; #3;
    chk("fetch_req", {31'h0, imem_req}, 32'h1);
    chk("fetch_busy", {31'h0, busy}, 32'h1);
    @(negedge clk); imem_rvalid = 0; b_sel = 2; #3;
    chk("mbr_sext", b_bus, 32'hFFFF_FF9C);
    b_sel = 3; #1; chk("mbr_zext", b_bus, 32'h0000_009C);
    @(negedge clk); rd = 1; wr = 1;
    @(negedge clk); rd = 0; wr = 0; #3;
    chk("clash_drop", {30'h0, dmem_rd, dmem_wr}, 32'h0);
    chk("clash_err", {31'h0, err}, {31'h0, exp_err_en});
    @(negedge clk); rd = 1;
    @(negedge clk); #3; chk("rd2_first", {31'h0, dmem_rd}, 32'h1);
    @(negedge clk); rd = 0; dmem_rvalid = 1; #3;
    chk("rd2_dropped", {31'h0, dmem_rd}, 32'h0);
    @(negedge clk); dmem_rvalid = 0; #3;
    chk("rd2_busy_clr", {31'h0, busy}, 32'h0);
    @(negedge clk); wr = 1;
    @(negedge clk); wr = 0; #3;
    chk("wr_pulse", {31'h0, dmem_wr}, 32'h1);
    chk("wr_no_busy", {31'h0, busy}, 32'h0);
    chk("err_sticky", {31'h0, err}, {31'h0, exp_err_en});
    @(negedge clk); #4 rst_n = 0;
    @(negedge clk); b_sel = 4; #3;
    chk("rst2_err", {31'h0, err}, 32'h0);
    chk("rst2_sp", b_bus, 32'h8000);
    rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = !(i >= 1500 && i < 1503);
      c_bus = $urandom;
      c_sel = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h0;
      b_sel = 4'($urandom);
      rd = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 7) == 0);
      fetch = ($urandom_range(0, 5) == 0);
      dmem_rvalid = ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      imem_rvalid = ($urandom_range(0, 2) == 0);
      imem_rdata = 8'($urandom);
    end
    @(negedge clk); #5;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
